// File: rtl/sensor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sensor_pkg
// Purpose  : Shared register map, burst geometry and sequencer state type
//            for the sensor measurement sequencer.
// Revision : 1.0  initial release
// ============================================================================
package sensor_pkg;

   localparam logic [6:0] CTRL_HUM  = 7'h72;
   localparam logic [6:0] STATUS    = 7'h73;
   localparam logic [6:0] CTRL_MEAS = 7'h74;
   localparam logic [6:0] DATA_BASE = 7'h77;

   localparam int BURST_LEN            = 8;
   localparam int STATUS_MEASURING_BIT = 3;

   typedef enum logic [3:0] {
      S_INIT_HUM  = 4'd0,
      S_INIT_MEAS = 4'd1,
      S_IDLE      = 4'd2,
      S_TRIG      = 4'd3,
      S_POLL_WAIT = 4'd4,
      S_POLL      = 4'd5,
      S_BURST     = 4'd6,
      S_DONE      = 4'd7,
      S_ABORT     = 4'd8
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/meas_period_timer.sv
`default_nettype none
// ============================================================================
// Module   : meas_period_timer
// Purpose  : Free-running measurement period counter plus a single-depth
//            pending-request flag fed by the period wrap and meas_req.
// Revision : 1.0  initial release
// ============================================================================
module meas_period_timer #(
   parameter int PERIOD = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic meas_req,
   input  logic consume,
   output logic pending
);

   localparam int PW = $clog2(PERIOD);

   logic [PW-1:0] r_cnt;
   logic          r_pending;
   logic          w_wrap;

   assign w_wrap = enable && (r_cnt == PW'(PERIOD - 1));

   // Period counter is held at zero while disabled; a new request in the
   // consume cycle re-arms pending so it is not lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt     <= '0;
         r_pending <= 1'b0;
      end else begin
         if (!enable || w_wrap) r_cnt <= '0;
         else                   r_cnt <= r_cnt + PW'(1);
         r_pending <= (r_pending && !consume) || meas_req || w_wrap;
      end
   end

   assign pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/sensor_meas_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sensor_meas_sequencer
// Purpose  : Drives the SPI master through sensor configuration, forced-mode
//            trigger, status polling and an 8-byte data burst, then presents
//            the assembled raw pressure/temperature/humidity words.
// Revision : 1.0  initial release
// ============================================================================
module sensor_meas_sequencer
   import sensor_pkg::*;
#(
   parameter int         PERIOD        = 50_000_000,
   parameter int         POLL_GAP      = 1000,
   parameter int         TIMEOUT_POLLS = 255,
   parameter logic [7:0] CTRL_HUM_VAL  = 8'h01,
   parameter logic [7:0] CTRL_MEAS_VAL = 8'h25
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        meas_req,
   output logic        spi_start,
   output logic        spi_read,
   output logic [6:0]  spi_addr,
   output logic [7:0]  spi_wdata,
   input  logic        spi_done,
   input  logic [7:0]  spi_rdata,
   output logic [19:0] press_raw,
   output logic [19:0] temp_raw,
   output logic [15:0] hum_raw,
   output logic        data_valid,
   output logic        busy,
   output logic        timeout_err
);

   localparam int GW = $clog2(POLL_GAP + 1);

   seq_state_t    r_state, w_state;
   logic          r_out, w_out;          // a transaction is outstanding
   logic [7:0]    r_poll, w_poll;
   logic [2:0]    r_idx, w_idx;
   logic [GW-1:0] r_gap, w_gap;
   logic          r_start, w_start;
   logic          r_read, w_read;
   logic [6:0]    r_addr, w_addr;
   logic [7:0]    r_wdata, w_wdata;
   logic [19:0]   r_press, w_press, r_temp, w_temp;
   logic [15:0]   r_hum, w_hum;
   logic          r_dv, w_dv, r_busy, w_busy, r_err, w_err;

   logic          w_txn, w_txn_read;
   logic [6:0]    w_txn_addr;
   logic [7:0]    w_txn_wdata;
   logic          w_ack, w_consume, w_buf_we, w_pending;
   logic [7:0]    r_buf [BURST_LEN];

   meas_period_timer #(.PERIOD(PERIOD)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .meas_req (meas_req),
      .consume  (w_consume),
      .pending  (w_pending)
   );

   // State register; every port-visible output is registered so reset
   // forces all of them to zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_INIT_HUM;
         r_out   <= 1'b0;
         r_poll  <= '0;
         r_idx   <= '0;
         r_gap   <= '0;
         r_start <= 1'b0;
         r_read  <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_press <= '0;
         r_temp  <= '0;
         r_hum   <= '0;
         r_dv    <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_out   <= w_out;
         r_poll  <= w_poll;
         r_idx   <= w_idx;
         r_gap   <= w_gap;
         r_start <= w_start;
         r_read  <= w_read;
         r_addr  <= w_addr;
         r_wdata <= w_wdata;
         r_press <= w_press;
         r_temp  <= w_temp;
         r_hum   <= w_hum;
         r_dv    <= w_dv;
         r_busy  <= w_busy;
         r_err   <= w_err;
      end
   end

   // Shadow buffer captures each burst byte in its completion cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < BURST_LEN; i++) r_buf[i] <= '0;
      end else if (w_buf_we) begin
         r_buf[r_idx] <= spi_rdata;
      end
   end

   // Next-state logic: each SPI state names its transaction, a shared block
   // issues it once, and the state advances on the matching spi_done.
   always_comb begin
      w_state     = r_state;
      w_out       = r_out;
      w_poll      = r_poll;
      w_idx       = r_idx;
      w_gap       = r_gap;
      w_start     = 1'b0;
      w_read      = r_read;
      w_addr      = r_addr;
      w_wdata     = r_wdata;
      w_press     = r_press;
      w_temp      = r_temp;
      w_hum       = r_hum;
      w_dv        = 1'b0;
      w_err       = r_err;
      w_consume   = 1'b0;
      w_buf_we    = 1'b0;
      w_txn       = 1'b0;
      w_txn_read  = 1'b0;
      w_txn_addr  = CTRL_HUM;
      w_txn_wdata = 8'h00;
      w_ack       = r_out && spi_done;

      case (r_state)
         S_INIT_HUM: begin
            w_txn       = 1'b1;
            w_txn_addr  = CTRL_HUM;
            w_txn_wdata = CTRL_HUM_VAL;
            if (w_ack) w_state = S_INIT_MEAS;
         end
         S_INIT_MEAS: begin
            w_txn       = 1'b1;
            w_txn_addr  = CTRL_MEAS;
            w_txn_wdata = CTRL_MEAS_VAL;
            if (w_ack) w_state = S_IDLE;
         end
         S_IDLE: begin
            if (w_pending) begin
               w_consume = 1'b1;
               w_state   = S_TRIG;
            end
         end
         S_TRIG: begin
            w_txn       = 1'b1;
            w_txn_addr  = CTRL_MEAS;
            w_txn_wdata = CTRL_MEAS_VAL;
            if (w_ack) begin
               w_poll  = '0;
               w_gap   = '0;
               w_state = S_POLL_WAIT;
            end
         end
         S_POLL_WAIT: begin
            if (int'(r_gap) + 1 >= POLL_GAP) w_state = S_POLL;
            else                             w_gap   = r_gap + GW'(1);
         end
         S_POLL: begin
            w_txn      = 1'b1;
            w_txn_read = 1'b1;
            w_txn_addr = STATUS;
            if (w_ack) begin
               w_poll = r_poll + 8'd1;
               if (!spi_rdata[STATUS_MEASURING_BIT]) begin
                  w_idx   = '0;
                  w_state = S_BURST;
               end else if (int'(w_poll) == TIMEOUT_POLLS) begin
                  w_state = S_ABORT;
               end else begin
                  w_gap   = '0;
                  w_state = S_POLL_WAIT;
               end
            end
         end
         S_BURST: begin
            w_txn      = 1'b1;
            w_txn_read = 1'b1;
            w_txn_addr = DATA_BASE + {4'b0000, r_idx};
            if (w_ack) begin
               w_buf_we = 1'b1;
               if (r_idx == 3'(BURST_LEN - 1)) w_state = S_DONE;
               else                            w_idx   = r_idx + 3'd1;
            end
         end
         S_DONE: begin
            w_press = {r_buf[0], r_buf[1], r_buf[2][7:4]};
            w_temp  = {r_buf[3], r_buf[4], r_buf[5][7:4]};
            w_hum   = {r_buf[6], r_buf[7]};
            w_dv    = 1'b1;
            w_err   = 1'b0;
            w_state = S_IDLE;
         end
         S_ABORT: begin
            w_err   = 1'b1;
            w_state = S_IDLE;
         end
         default: w_state = S_IDLE;
      endcase

      if (w_txn && !r_out) begin
         w_start = 1'b1;
         w_out   = 1'b1;
         w_read  = w_txn_read;
         w_addr  = w_txn_addr;
         w_wdata = w_txn_wdata;
      end
      if (w_ack) w_out = 1'b0;

      w_busy = (w_state != S_IDLE);
   end

   assign spi_start   = r_start;
   assign spi_read    = r_read;
   assign spi_addr    = r_addr;
   assign spi_wdata   = r_wdata;
   assign press_raw   = r_press;
   assign temp_raw    = r_temp;
   assign hum_raw     = r_hum;
   assign data_valid  = r_dv;
   assign busy        = r_busy;
   assign timeout_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sensor_meas_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_meas_sequencer
// Purpose  : Self-checking bench: SPI slave model with a transaction-level
//            expectation of the sensor access sequence, plus a per-cycle
//            output comparator against the bench's own result model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sensor_meas_sequencer;

   localparam int PERIOD   = 200;
   localparam int POLL_GAP = 5;
   localparam int TMO      = 4;

   logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, meas_req = 1'b0;
   logic        spi_done = 1'b0;
   logic [7:0]  spi_rdata = 8'h00;
   logic        spi_start, spi_read, data_valid, busy, timeout_err;
   logic [6:0]  spi_addr;
   logic [7:0]  spi_wdata;
   logic [19:0] press_raw, temp_raw;
   logic [15:0] hum_raw;

   always #5 clk = ~clk;

   sensor_meas_sequencer #(
      .PERIOD(PERIOD), .POLL_GAP(POLL_GAP), .TIMEOUT_POLLS(TMO),
      .CTRL_HUM_VAL(8'h01), .CTRL_MEAS_VAL(8'h25)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .meas_req(meas_req),
      .spi_start(spi_start), .spi_read(spi_read), .spi_addr(spi_addr),
      .spi_wdata(spi_wdata), .spi_done(spi_done), .spi_rdata(spi_rdata),
      .press_raw(press_raw), .temp_raw(temp_raw), .hum_raw(hum_raw),
      .data_valid(data_valid), .busy(busy), .timeout_err(timeout_err)
   );

   int checks = 0, errors = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---- model state ----
   int          g_phase = 0;    // 0 init hum, 1 init meas, 2 trigger, 3 status, 4 data
   int          g_idx = 0, g_polls = 0, busy_left = 0;
   logic [7:0]  bytes [8];
   logic [7:0]  cur   [8];
   logic [19:0] m_press = '0, m_temp = '0;
   logic [15:0] m_hum = '0;
   logic        m_err = 1'b0;
   int          dv_due = 0, dv_cnt = 0, ends = 0, lat_fixed = 20;
   int          n_writes = 0, n_status = 0, n_trig = 0, last_done = 0;
   bit          rec_trig = 0, sl_out = 0, byte4_seen = 0;
   int          sl_cnt = 0;
   int          trig_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // SPI slave: checks each transaction against the expected access sequence
   // and answers it after a (random or fixed) latency.
   initial begin
      forever begin
         @(negedge clk);
         spi_done  = 1'b0;
         spi_rdata = 8'($urandom);
         if (!reset) begin
            sl_out = 0;
            continue;
         end
         if (spi_start) begin
            chk("no_overlap", 64'(sl_out), 0);
            chk("busy_on_start", 64'(busy), 1);
            case (g_phase)
               0: chk("txn_init_hum", {spi_read, spi_addr, spi_wdata}, {1'b0, 7'h72, 8'h01});
               1: chk("txn_init_meas", {spi_read, spi_addr, spi_wdata}, {1'b0, 7'h74, 8'h25});
               2: begin
                  chk("txn_trig", {spi_read, spi_addr, spi_wdata}, {1'b0, 7'h74, 8'h25});
                  n_trig++;
                  if (rec_trig) trig_q.push_back(cyc);
               end
               3: begin
                  chk("txn_status", {spi_read, spi_addr}, {1'b1, 7'h73});
                  chk("poll_gap", 64'(cyc - last_done >= POLL_GAP), 1);
                  n_status++;
               end
               default: begin
                  chk("txn_data", {spi_read, spi_addr}, {1'b1, 7'(7'h77 + g_idx)});
                  if (g_idx == 4) byte4_seen = 1;
               end
            endcase
            if (!spi_read) n_writes++;
            sl_out = 1;
            sl_cnt = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 6));
         end else if (sl_out) begin
            sl_cnt--;
            if (sl_cnt == 0) begin
               sl_out    = 0;
               last_done = cyc;
               spi_done  = 1'b1;
               case (g_phase)
                  0: g_phase = 1;
                  1: g_phase = 2;
                  2: begin g_phase = 3; g_polls = 0; end
                  3: begin
                     g_polls++;
                     if (busy_left > 0) begin
                        busy_left--;
                        spi_rdata = 8'($urandom) | 8'h08;
                        if (g_polls == TMO) begin
                           m_err = 1'b1;
                           ends++;
                           g_phase = 2;
                        end
                     end else begin
                        spi_rdata = 8'($urandom) & 8'hF7;
                        g_idx   = 0;
                        g_phase = 4;
                     end
                  end
                  default: begin
                     spi_rdata   = bytes[g_idx];
                     cur[g_idx]  = bytes[g_idx];
                     if (g_idx == 7) begin
                        m_press = (20'(cur[0]) << 12) | (20'(cur[1]) << 4) | 20'(cur[2] >> 4);
                        m_temp  = (20'(cur[3]) << 12) | (20'(cur[4]) << 4) | 20'(cur[5] >> 4);
                        m_hum   = (16'(cur[6]) << 8) | 16'(cur[7]);
                        m_err   = 1'b0;
                        dv_due  = 1;
                        ends++;
                        g_phase = 2;
                     end else begin
                        g_idx++;
                     end
                  end
               endcase
            end
         end else if (!busy && $urandom_range(0, 15) == 0) begin
            spi_done = 1'b1;   // stray completion with nothing outstanding
         end
      end
   end

   // Per-cycle comparator: strobe must be expected; when idle, held outputs
   // must match the model.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            if (data_valid) begin
               chk("dv_expected", 64'(dv_due), 1);
               dv_due = 0;
               dv_cnt++;
            end
            if (!busy) begin
               chk("press_raw", 64'(press_raw), 64'(m_press));
               chk("temp_raw", 64'(temp_raw), 64'(m_temp));
               chk("hum_raw", 64'(hum_raw), 64'(m_hum));
               chk("timeout_err", 64'(timeout_err), 64'(m_err));
               chk("dv_missing", 64'(dv_due), 0);
            end
         end
      end
   end

   task automatic pulse_req();
      @(negedge clk) meas_req = 1'b1;
      @(negedge clk) meas_req = 1'b0;
   endtask

   task automatic wait_ends(input int n, input string name);
      int b = 0;
      while (ends < n && b < 3000) begin @(negedge clk); b++; end
      chk({name, "_end"}, 64'(ends >= n), 1);
      b = 0;
      while (busy && b < 20) begin @(negedge clk); b++; end
      chk({name, "_idle"}, 64'(busy), 0);
   endtask

   task automatic wait_init(input string name);
      int b = 0;
      while (!(n_writes == 2 && !busy && !sl_out) && b < 400) begin @(negedge clk); b++; end
      chk({name, "_writes"}, 64'(n_writes), 2);
      chk({name, "_busy"}, 64'(busy), 0);
   endtask

   task automatic rand_bytes();
      for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e, d, s, b;
      logic [19:0] p_save;
      for (int i = 0; i < 8; i++) bytes[i] = 8'(8'h11 * (i + 1));

      // Reset state
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      chk("reset_outputs", {spi_start, spi_read, spi_addr, spi_wdata, press_raw, temp_raw,
                            hum_raw, data_valid, busy, timeout_err}, 0);
      @(negedge clk) reset = 1'b1;

      // Configuration writes with a slow slave
      wait_init("init");
      repeat (30) @(negedge clk);
      chk("init_no_extra_txn", 64'(n_writes), 2);
      chk("init_outputs", {spi_start, press_raw, temp_raw, hum_raw, data_valid, timeout_err}, 0);

      // Single measurement, known bytes
      lat_fixed = 0; busy_left = 0;
      pulse_req();
      wait_ends(1, "meas1");
      repeat (3) @(negedge clk);
      chk("meas1_dv_count", 64'(dv_cnt), 1);
      chk("meas1_press_lit", 64'(press_raw), 64'h11223);
      chk("meas1_temp_lit", 64'(temp_raw), 64'h44556);
      chk("meas1_hum_lit", 64'(hum_raw), 64'h7788);

      // Three busy polls then ready
      rand_bytes(); busy_left = 3; s = n_status;
      pulse_req();
      wait_ends(2, "poll3");
      chk("poll3_status_reads", 64'(n_status - s), 4);
      chk("poll3_dv_count", 64'(dv_cnt), 2);
      chk("poll3_err", 64'(timeout_err), 0);

      // Timeout: status stuck busy
      p_save = m_press; busy_left = 1000; s = n_status;
      pulse_req();
      wait_ends(3, "tmo");
      repeat (2) @(negedge clk);
      chk("tmo_status_reads", 64'(n_status - s), TMO);
      chk("tmo_err", 64'(timeout_err), 1);
      chk("tmo_no_dv", 64'(dv_cnt), 2);
      chk("tmo_raw_kept", 64'(press_raw), 64'(p_save));

      // Next good run clears the error
      rand_bytes(); busy_left = 0;
      pulse_req();
      wait_ends(4, "recover");
      repeat (2) @(negedge clk);
      chk("recover_err", 64'(timeout_err), 0);

      // Requests during a burst collapse into one extra measurement
      rand_bytes(); busy_left = 1; d = dv_cnt; e = ends; s = n_trig;
      pulse_req();
      b = 0;
      while (g_phase != 4 && b < 500) begin @(negedge clk); b++; end
      chk("collapse_reached_burst", 64'(g_phase), 4);
      repeat (3) begin pulse_req(); @(negedge clk); end
      wait_ends(e + 2, "collapse");
      repeat (300) @(negedge clk);
      chk("collapse_dv", 64'(dv_cnt - d), 2);
      chk("collapse_trig", 64'(n_trig - s), 2);

      // Randomised single shots
      for (int it = 0; it < 6; it++) begin
         rand_bytes(); busy_left = int'($urandom_range(0, 2)); d = dv_cnt;
         repeat ($urandom_range(0, 20)) @(negedge clk);
         pulse_req();
         wait_ends(ends + 1, "rand");
         repeat (2) @(negedge clk);
         chk("rand_dv", 64'(dv_cnt - d), 1);
      end

      // Periodic triggering
      busy_left = 0; rec_trig = 1; trig_q.delete(); e = ends;
      @(negedge clk) enable = 1'b1;
      repeat (1050) begin
         if (g_phase == 2 && !sl_out) rand_bytes();
         @(negedge clk);
      end
      enable = 1'b0;
      wait_ends(e + 5, "period");
      repeat (250) @(negedge clk);
      rec_trig = 0;
      chk("period_trig_count", 64'(trig_q.size()), 5);
      for (int i = 1; i < trig_q.size(); i++)
         chk("period_spacing", 64'(trig_q[i] - trig_q[i-1]), PERIOD);

      // Reset in the middle of the burst
      rand_bytes(); busy_left = 0; byte4_seen = 0; lat_fixed = 4;
      pulse_req();
      b = 0;
      while (!byte4_seen && b < 500) begin @(negedge clk); b++; end
      chk("burst_byte4_reached", 64'(byte4_seen), 1);
      @(posedge clk); #2;
      reset = 1'b0;
      g_phase = 0; n_writes = 0; dv_due = 0;
      m_press = '0; m_temp = '0; m_hum = '0; m_err = 1'b0;
      #1;
      chk("reset_mid_burst_outputs", {spi_start, spi_read, spi_addr, spi_wdata, press_raw,
                                      temp_raw, hum_raw, data_valid, busy, timeout_err}, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1; lat_fixed = 3;
      wait_init("restart");
      lat_fixed = 0; rand_bytes(); d = dv_cnt;
      pulse_req();
      wait_ends(ends + 1, "after_reset");
      repeat (2) @(negedge clk);
      chk("after_reset_dv", 64'(dv_cnt - d), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
